fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_if.sv | 30 +++
 rtl/fifo_stream_reader.sv | 121 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_stream_reader_if : upstream FIFO pop port plus downstream stream port
// Revision 1.0
// ---------------------------------------------------------------------------
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_valid;
    logic                  fifo_empty;
    logic                  fifo_shift_out;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [15:0]           beat_count;
    logic                  overrun;

    modport master (
        input  fifo_dout, fifo_valid, fifo_empty, m_ready,
        output fifo_shift_out, m_data, m_valid, m_last, beat_count, overrun
    );

    modport slave (
        output fifo_dout, fifo_valid, fifo_empty, m_ready,
        input  fifo_shift_out, m_data, m_valid, m_last, beat_count, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_stream_reader : pops a sync FIFO into a 2-entry skid buffer, streams out
//                      packets of PKT_LEN beats with last/count/overrun status
// Revision 1.0
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 0,
    parameter int PKT_LEN      = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fifo_stream_reader_if.master  bus
);
    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  inflight_q, inflight_d;
    logic [15:0]           pkt_idx_q, pkt_idx_d;
    logic [15:0]           beat_count_q, beat_count_d;
    logic                  overrun_q, overrun_d;

    logic                  w_valid;
    logic                  w_xfer;
    logic                  w_push;
    logic                  w_shift;
    logic [2:0]            w_level;

    assign w_valid = (occ_q != 2'd0);
    assign w_xfer  = w_valid && bus.m_ready;
    assign w_push  = bus.fifo_valid && !rst;

    // Occupancy after this cycle's beat leaves, counting any word still in flight.
    assign w_level = {1'b0, occ_q} - {2'b00, w_xfer} + {2'b00, inflight_q};
    assign w_shift = !rst && !bus.fifo_empty && (w_level < 3'd2);

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign inflight_d = w_shift;
        end else begin : g_lat0
            assign inflight_d = 1'b0;
        end
    endgenerate

    always_comb begin
        occ_d        = occ_q;
        head_d       = head_q;
        tail_d       = tail_q;
        pkt_idx_d    = pkt_idx_q;
        beat_count_d = beat_count_q;
        overrun_d    = overrun_q;

        if (w_xfer) begin
            pkt_idx_d    = (pkt_idx_q == LAST_IDX) ? 16'd0 : pkt_idx_q + 16'd1;
            beat_count_d = beat_count_q + 16'd1;
        end

        case ({w_push, w_xfer})
            2'b10: begin
                case (occ_q)
                    2'd0: begin
                        head_d = bus.fifo_dout;
                        occ_d  = 2'd1;
                    end
                    2'd1: begin
                        tail_d = bus.fifo_dout;
                        occ_d  = 2'd2;
                    end
                    default: overrun_d = 1'b1;
                endcase
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever remains.
                if (occ_q == 2'd1) begin
                    head_d = bus.fifo_dout;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.fifo_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            pkt_idx_q    <= 16'd0;
            beat_count_q <= 16'd0;
            overrun_q    <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            pkt_idx_q    <= pkt_idx_d;
            beat_count_q <= beat_count_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign bus.fifo_shift_out = w_shift;
    assign bus.m_data         = head_q;
    assign bus.m_valid        = w_valid;
    assign bus.m_last         = w_valid && (pkt_idx_q == LAST_IDX);
    assign bus.beat_count     = beat_count_q;
    assign bus.overrun        = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_stream_reader : scoreboard bench for both read latencies, PKT_LEN=4
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fifo_stream_reader;
    localparam int          PKT = 4;
    localparam logic [31:0] INJ = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(32)) if0 ();
    fifo_stream_reader_if #(.DATA_WIDTH(32)) if1 ();

    fifo_stream_reader #(.DATA_WIDTH(32), .READ_LATENCY(0), .PKT_LEN(PKT)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    fifo_stream_reader #(.DATA_WIDTH(32), .READ_LATENCY(1), .PKT_LEN(PKT)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    // Upstream FIFO model state; lane selects which DUT is live (lane = latency).
    logic        lane;
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    logic        f_empty;
    logic [31:0] f_head;
    logic        v_reg;
    logic [31:0] v_data;
    logic        inject;
    logic        m_ready;

    assign if0.fifo_empty = (lane == 1'b0) ? f_empty : 1'b1;
    assign if1.fifo_empty = (lane == 1'b1) ? f_empty : 1'b1;
    assign if0.fifo_valid = (lane == 1'b0) && (if0.fifo_shift_out || inject);
    assign if1.fifo_valid = (lane == 1'b1) && (v_reg || inject);
    assign if0.fifo_dout  = inject ? INJ : f_head;
    assign if1.fifo_dout  = inject ? INJ : v_data;
    assign if0.m_ready    = (lane == 1'b0) && m_ready;
    assign if1.m_ready    = (lane == 1'b1) && m_ready;

    logic        w_shift, w_mv, w_ml, w_ovr;
    logic [31:0] w_md;
    logic [15:0] w_bc;
    assign w_shift = lane ? if1.fifo_shift_out : if0.fifo_shift_out;
    assign w_mv    = lane ? if1.m_valid        : if0.m_valid;
    assign w_ml    = lane ? if1.m_last         : if0.m_last;
    assign w_md    = lane ? if1.m_data         : if0.m_data;
    assign w_bc    = lane ? if1.beat_count     : if0.beat_count;
    assign w_ovr   = lane ? if1.overrun        : if0.overrun;

    int tests, errors, cyc, exp_idx, beats, first_pop, first_mv, last_xfer;
    logic        hold_prev;
    logic [31:0] hold_data;
    logic        s_shift, s_mv, s_ml, s_rdy;
    logic [31:0] s_md;

    task automatic refresh();
        f_empty = (src_q.size() == 0);
        f_head  = (src_q.size() != 0) ? src_q[0] : 32'h0;
    endtask

    task automatic push_word(input logic [31:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        refresh();
    endtask

    task automatic sample();
        logic [31:0] e;
        s_shift = w_shift;
        s_mv    = w_mv;
        s_md    = w_md;
        s_ml    = w_ml;
        s_rdy   = m_ready;
        if (f_empty) begin
            tests++;
            if (s_shift !== 1'b0) begin
                errors++;
                $display("FAIL underflow: shift_out=%b required 0 while fifo_empty", s_shift);
            end
        end
        if (first_pop < 0 && s_shift) first_pop = cyc;
        if (first_mv < 0 && s_mv) first_mv = cyc;
        if (hold_prev && !rst) begin
            tests++;
            if (s_mv !== 1'b1 || s_md !== hold_data) begin
                errors++;
                $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", s_mv, s_md, hold_data);
            end
        end
        if (s_mv && s_rdy) begin
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected beat data=%h, none required", s_md);
            end else begin
                e = exp_q.pop_front();
                if (s_md !== e || s_ml !== (exp_idx == PKT - 1)) begin
                    errors++;
                    $display("FAIL scoreboard: data=%h last=%b required data=%h last=%b",
                             s_md, s_ml, e, (exp_idx == PKT - 1));
                end
            end
            exp_idx   = (exp_idx + 1) % PKT;
            beats++;
            last_xfer = cyc;
        end
        hold_prev = s_mv && !s_rdy && !rst;
        hold_data = s_md;
    endtask

    task automatic advance();
        logic [31:0] d;
        cyc++;
        if (s_shift && src_q.size() != 0) begin
            d = src_q.pop_front();
            v_reg  = lane;
            v_data = d;
        end else begin
            v_reg = 1'b0;
        end
        refresh();
    endtask

    task automatic finish_cycle();
        sample();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats still outstanding, required 0", exp_q.size());
        end
    endtask

    // Reset for ncyc cycles with nwords preloaded, then check the first free cycle.
    task automatic test_reset(input logic l, input int ncyc, input int nwords, input logic [31:0] base);
        lane = l; m_ready = 1'b0; inject = 1'b0; rst = 1'b1;
        src_q.delete(); exp_q.delete();
        v_reg = 1'b0; exp_idx = 0; beats = 0; hold_prev = 1'b0;
        first_pop = -1; first_mv = -1; last_xfer = -1;
        for (int i = 0; i < nwords; i++) push_word(base + 32'(i));
        refresh();
        repeat (ncyc) begin
            @(negedge clk);
            tests++;
            if (w_shift !== 1'b0) begin
                errors++;
                $display("FAIL rst_shift: shift_out=%b required 0", w_shift);
            end
            finish_cycle();
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (w_mv !== 1'b0 || w_ml !== 1'b0 || w_bc !== 16'd0 || w_ovr !== 1'b0 ||
            w_shift !== (src_q.size() != 0)) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b count=%h overrun=%b shift=%b required 0 0 0000 0 %b",
                     w_mv, w_ml, w_bc, w_ovr, w_shift, (src_q.size() != 0));
        end
        finish_cycle();
    endtask

    task automatic test_stream(input logic l);
        test_reset(l, 2, 8, 32'd0);
        drain(100);
        tests++;
        if (first_mv - first_pop != int'(l) + 1) begin
            errors++;
            $display("FAIL latency: pop-to-valid=%0d required %0d", first_mv - first_pop, int'(l) + 1);
        end
        tests++;
        if (beats != 8 || last_xfer - first_mv != 7) begin
            errors++;
            $display("FAIL throughput: beats=%0d span=%0d required 8 and 7", beats, last_xfer - first_mv);
        end
        tests++;
        if (w_bc !== 16'd8 || w_ovr !== 1'b0) begin
            errors++;
            $display("FAIL stream_status: count=%0d overrun=%b required 8 0", w_bc, w_ovr);
        end
    endtask

    task automatic test_backpressure(input logic l);
        test_reset(l, 2, 5, 32'h100);
        repeat (10) tick();
        @(negedge clk);
        tests++;
        if (w_mv !== 1'b1 || w_shift !== 1'b0 || w_md !== 32'h100 || src_q.size() != 3) begin
            errors++;
            $display("FAIL backpressure: valid=%b shift=%b data=%h fifo_left=%0d required 1 0 00000100 3",
                     w_mv, w_shift, w_md, src_q.size());
        end
        finish_cycle();
        drain(100);
        tests++;
        if (w_bc !== 16'd5) begin
            errors++;
            $display("FAIL bp_count: count=%0d required 5", w_bc);
        end
    endtask

    task automatic test_random(input logic l);
        int sent = 0;
        int n    = 0;
        test_reset(l, 2, 0, 32'd0);
        while ((sent < 1000 || exp_q.size() != 0) && n < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (sent < 1000 && $urandom_range(0, 1) == 1) begin
                push_word($urandom());
                sent++;
            end
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0 || w_bc !== 16'd1000 || w_ovr !== 1'b0) begin
            errors++;
            $display("FAIL random: left=%0d count=%0d overrun=%b required 0 1000 0", exp_q.size(), w_bc, w_ovr);
        end
    endtask

    task automatic test_overrun(input logic l);
        test_reset(l, 2, 2, 32'h200);
        repeat (6) tick();
        inject = 1'b1;
        @(negedge clk);
        tests++;
        if (w_ovr !== 1'b0 || w_mv !== 1'b1 || w_shift !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: overrun=%b valid=%b shift=%b required 0 1 0", w_ovr, w_mv, w_shift);
        end
        finish_cycle();
        inject = 1'b0;
        @(negedge clk);
        tests++;
        if (w_ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b required 1", w_ovr);
        end
        finish_cycle();
        drain(50);
        tests++;
        if (w_ovr !== 1'b1 || w_bc !== 16'd2) begin
            errors++;
            $display("FAIL overrun_sticky: overrun=%b count=%0d required 1 2", w_ovr, w_bc);
        end
    endtask

    task automatic test_mid_reset(input logic l);
        int n = 0;
        test_reset(l, 2, 8, 32'h300);
        m_ready = 1'b1;
        while (beats < 2 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (beats != 2) begin
            errors++;
            $display("FAIL mid_reset_pre: beats=%0d required 2", beats);
        end
        test_reset(l, 1, 4, 32'h400);
        drain(50);
        tests++;
        if (w_bc !== 16'd4 || beats != 4) begin
            errors++;
            $display("FAIL mid_reset_post: count=%0d beats=%0d required 4 4", w_bc, beats);
        end
    endtask

    initial begin
        tests = 0; errors = 0; cyc = 0;
        rst = 1'b1; lane = 1'b0; m_ready = 1'b0; inject = 1'b0;
        v_reg = 1'b0; v_data = 32'h0; hold_prev = 1'b0; hold_data = 32'h0;
        exp_idx = 0; beats = 0; first_pop = -1; first_mv = -1; last_xfer = -1;
        refresh();
        for (int l = 0; l < 2; l++) begin
            test_stream(1'(l));
            test_backpressure(1'(l));
            test_overrun(1'(l));
            test_mid_reset(1'(l));
            test_random(1'(l));
        end
        test_reset(1'b0, 2, 0, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
